vga_timing_core: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/vga_sync_delay.sv | 41 ++++
 rtl/vga_timing_core.sv | 124 ++++++++++++
 tb/tb_vga_timing_core.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing_pkg : 640x480@60 timing constants shared with the renderer |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  localparam logic VGA_HSYNC_POL = 1'b0;
  localparam logic VGA_VSYNC_POL = 1'b0;

  localparam int CNT_W = 10;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic display_on;
  } sync_bus_t;

  // Zero-extend a counter so compares see the full 32-bit constant
  function automatic logic [31:0] widen(input logic [CNT_W-1:0] v);
    return {{(32-CNT_W){1'b0}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_sync_delay : ce-qualified shift register for sync/blank alignment |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int        DEPTH   = 2,
  parameter sync_bus_t RST_VAL = '0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      ce,
  input  sync_bus_t din,
  output sync_bus_t dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, rst_n, ce};
      assign dout = din;
    end else begin : g_pipe
      sync_bus_t stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else if (ce) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing_core : VGA raster counters, sync/blank, strobes, frame count |
// | Revision        : 1.0                                                  |
// +----------------------------------------------------------------------+
module vga_timing_core
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE  = VGA_H_ACTIVE,
  parameter int   H_FP      = VGA_H_FP,
  parameter int   H_SYNC    = VGA_H_SYNC,
  parameter int   H_BP      = VGA_H_BP,
  parameter int   V_ACTIVE  = VGA_V_ACTIVE,
  parameter int   V_FP      = VGA_V_FP,
  parameter int   V_SYNC    = VGA_V_SYNC,
  parameter int   V_BP      = VGA_V_BP,
  parameter logic HSYNC_POL = VGA_HSYNC_POL,
  parameter logic VSYNC_POL = VGA_VSYNC_POL,
  parameter int   PIPE_DLY  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count,
  output logic       hsync_d,
  output logic       vsync_d,
  output logic       display_on_d
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [31:0] H_LAST   = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_LAST   = 32'(V_TOTAL - 1);
  localparam logic [31:0] H_ACT    = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT    = 32'(V_ACTIVE);
  localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_STOP  = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_STOP  = 32'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if (H_TOTAL > 1024) begin : g_bad_h_total
      $error("vga_timing_core: H_TOTAL does not fit a 10-bit counter");
    end
    if (V_TOTAL > 1024) begin : g_bad_v_total
      $error("vga_timing_core: V_TOTAL does not fit a 10-bit counter");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_pipe_dly
      $error("vga_timing_core: PIPE_DLY must be within 0..7");
    end
  endgenerate

  logic [9:0] h_next, v_next;
  logic       h_wrap, v_wrap;
  logic       de_next, hs_next, vs_next;

  // Outputs are decoded from the next counter values so they register
  // coherently with hpos/vpos.
  always_comb begin
    h_wrap  = (widen(hpos) == H_LAST);
    v_wrap  = h_wrap && (widen(vpos) == V_LAST);
    h_next  = h_wrap ? '0 : hpos + 10'd1;
    v_next  = v_wrap ? '0 : (h_wrap ? vpos + 10'd1 : vpos);
    de_next = (widen(h_next) < H_ACT) && (widen(v_next) < V_ACT);
    hs_next = (widen(h_next) >= HS_START && widen(h_next) < HS_STOP) ? HSYNC_POL : ~HSYNC_POL;
    vs_next = (widen(v_next) >= VS_START && widen(v_next) < VS_STOP) ? VSYNC_POL : ~VSYNC_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos        <= '0;
      vpos        <= '0;
      display_on  <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else if (ce) begin
      hpos        <= h_next;
      vpos        <= v_next;
      display_on  <= de_next;
      hsync       <= hs_next;
      vsync       <= vs_next;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      if (v_wrap) frame_count <= frame_count + 8'd1;
    end else begin
      // Strobes must never stretch across stalled cycles
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  localparam sync_bus_t IDLE = sync_bus_t'{hsync: ~HSYNC_POL, vsync: ~VSYNC_POL, display_on: 1'b0};

  sync_bus_t dly_in, dly_out;
  assign dly_in = sync_bus_t'{hsync: hsync, vsync: vsync, display_on: display_on};

  vga_sync_delay #(
    .DEPTH   (PIPE_DLY),
    .RST_VAL (IDLE)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .din   (dly_in),
    .dout  (dly_out)
  );

  assign hsync_d      = dly_out.hsync;
  assign vsync_d      = dly_out.vsync;
  assign display_on_d = dly_out.display_on;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_timing_core : scoreboard bench for three timing configurations |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_vga_timing_core;

  typedef struct packed {
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       display_on;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;
    logic       hsync_d;
    logic       vsync_d;
    logic       display_on_d;
  } out_t;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    bit hpol; bit vpol; int dly;
  } cfg_t;

  typedef struct { out_t a; out_t s; out_t p; } exp_t;

  localparam cfg_t CA = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, hpol:1'b0, vpol:1'b0, dly:2};
  localparam cfg_t CS = '{ha:8, hf:2, hs:3, hb:3, va:4, vf:1, vs:2, vb:1, hpol:1'b0, vpol:1'b0, dly:2};
  localparam cfg_t CP = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, hpol:1'b1, vpol:1'b0, dly:0};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ce    = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] a_hpos, a_vpos, s_hpos, s_vpos, p_hpos, p_vpos;
  logic [7:0] a_fc, s_fc, p_fc;
  logic a_de, a_hs, a_vs, a_ls, a_fs, a_hsd, a_vsd, a_ded;
  logic s_de, s_hs, s_vs, s_ls, s_fs, s_hsd, s_vsd, s_ded;
  logic p_de, p_hs, p_vs, p_ls, p_fs, p_hsd, p_vsd, p_ded;

  vga_timing_core dut_a (
    .clk(clk), .rst_n(rst_n), .ce(ce), .hpos(a_hpos), .vpos(a_vpos),
    .display_on(a_de), .hsync(a_hs), .vsync(a_vs), .line_start(a_ls),
    .frame_start(a_fs), .frame_count(a_fc), .hsync_d(a_hsd), .vsync_d(a_vsd),
    .display_on_d(a_ded));

  vga_timing_core #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DLY(2)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .ce(ce), .hpos(s_hpos), .vpos(s_vpos),
    .display_on(s_de), .hsync(s_hs), .vsync(s_vs), .line_start(s_ls),
    .frame_start(s_fs), .frame_count(s_fc), .hsync_d(s_hsd), .vsync_d(s_vsd),
    .display_on_d(s_ded));

  vga_timing_core #(
    .HSYNC_POL(1'b1), .PIPE_DLY(0)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .ce(ce), .hpos(p_hpos), .vpos(p_vpos),
    .display_on(p_de), .hsync(p_hs), .vsync(p_vs), .line_start(p_ls),
    .frame_start(p_fs), .frame_count(p_fc), .hsync_d(p_hsd), .vsync_d(p_vsd),
    .display_on_d(p_ded));

  out_t act_a, act_s, act_p;
  assign act_a = {a_hpos, a_vpos, a_de, a_hs, a_vs, a_ls, a_fs, a_fc, a_hsd, a_vsd, a_ded};
  assign act_s = {s_hpos, s_vpos, s_de, s_hs, s_vs, s_ls, s_fs, s_fc, s_hsd, s_vsd, s_ded};
  assign act_p = {p_hpos, p_vpos, p_de, p_hs, p_vs, p_ls, p_fs, p_fc, p_hsd, p_vsd, p_ded};

  int   vectors = 0;
  int   fails   = 0;
  exp_t sb[$];
  longint n = 0;  // ce cycles since reset; the model derives everything from it

  // Raster position after n advances; the reset point (n=0) is blanked
  function automatic bit [2:0] trip(cfg_t c, longint k);
    longint ht = c.ha + c.hf + c.hs + c.hb;
    longint vt = c.va + c.vf + c.vs + c.vb;
    longint h  = k % ht;
    longint v  = (k / ht) % vt;
    bit hs_on  = (h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs);
    bit vs_on  = (v >= c.va + c.vf) && (v < c.va + c.vf + c.vs);
    return {hs_on ? c.hpol : ~c.hpol, vs_on ? c.vpol : ~c.vpol, (k != 0) && (h < c.ha) && (v < c.va)};
  endfunction

  function automatic out_t model(cfg_t c, longint k, bit strobe);
    out_t o;
    longint ht = c.ha + c.hf + c.hs + c.hb;
    longint vt = c.va + c.vf + c.vs + c.vb;
    o.hpos        = 10'(k % ht);
    o.vpos        = 10'((k / ht) % vt);
    o.frame_count = 8'((k / (ht * vt)) % 256);
    {o.hsync, o.vsync, o.display_on} = trip(c, k);
    o.line_start  = strobe && (o.hpos == 10'd0);
    o.frame_start = strobe && (o.hpos == 10'd0) && (o.vpos == 10'd0);
    {o.hsync_d, o.vsync_d, o.display_on_d} = trip(c, (k >= c.dly) ? k - c.dly : 0);
    return o;
  endfunction

  task automatic push(input bit strobe);
    exp_t e;
    e.a = model(CA, n, strobe);
    e.s = model(CS, n, strobe);
    e.p = model(CP, n, strobe);
    sb.push_back(e);
  endtask

  task automatic cmp(input string name, input out_t act, input out_t req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s @%0t: got h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d d=%b%b%b, required h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d d=%b%b%b",
               name, $time, act.hpos, act.vpos, act.display_on, act.hsync, act.vsync, act.line_start,
               act.frame_start, act.frame_count, act.hsync_d, act.vsync_d, act.display_on_d,
               req.hpos, req.vpos, req.display_on, req.hsync, req.vsync, req.line_start,
               req.frame_start, req.frame_count, req.hsync_d, req.vsync_d, req.display_on_d);
    end
  endtask

  task automatic spot(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per clock edge or asynchronous reset edge
  always begin
    exp_t e;
    @(posedge clk or negedge rst_n);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cmp("std", act_a, e.a);
      cmp("small", act_s, e.s);
      cmp("pol", act_p, e.p);
    end
  end

  task automatic step(input bit ce_v);
    ce = ce_v;
    if (rst_n && ce_v) n++;
    push(rst_n && ce_v);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    n = 0;
    push(1'b0);
    rst_n = 1'b0;
    #2;
    spot("rst_a_hsync", a_hs, 1);   spot("rst_a_vsync", a_vs, 1);
    spot("rst_a_hsync_d", a_hsd, 1); spot("rst_a_vsync_d", a_vsd, 1);
    spot("rst_a_de_d", a_ded, 0);   spot("rst_a_hpos", a_hpos, 0); spot("rst_a_vpos", a_vpos, 0);
    spot("rst_s_hsync", s_hs, 1);   spot("rst_s_vsync", s_vs, 1);
    spot("rst_s_hsync_d", s_hsd, 1); spot("rst_s_vsync_d", s_vsd, 1);
    spot("rst_s_de_d", s_ded, 0);   spot("rst_s_hpos", s_hpos, 0); spot("rst_s_vpos", s_vpos, 0);
    spot("rst_p_hsync", p_hs, 0);
    @(negedge clk);
    step(1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d entries pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int ls_cnt, hs_cnt, hs_first, de0_cnt, phs_cnt, phs_first;
    int de_rise, ded_rise, fs_cnt, vs_low, vs_bad;
    ls_cnt = 0; hs_cnt = 0; hs_first = -1; de0_cnt = 0; phs_cnt = 0; phs_first = -1;
    de_rise = -1; ded_rise = -1; fs_cnt = 0; vs_low = 0; vs_bad = 0;

    @(negedge clk);
    step(1'b0);
    step(1'b1);
    rst_n = 1'b1;

    // One full line from reset
    for (int i = 0; i < 800; i++) begin
      step(1'b1);
      if (a_ls) ls_cnt++;
      if (!a_hs) begin if (hs_cnt == 0) hs_first = int'(a_hpos); hs_cnt++; end
      if (a_de && a_vpos == 10'd0) de0_cnt++;
      if (p_hs) begin if (phs_cnt == 0) phs_first = int'(p_hpos); phs_cnt++; end
    end
    spot("line_start_count", ls_cnt, 1);
    spot("line_start_at_wrap", a_ls, 1);
    spot("hsync_low_cycles", hs_cnt, 96);
    spot("hsync_first_hpos", hs_first, 656);
    spot("display_line0", de0_cnt, 639);
    spot("display_line1_px0", a_de, 1);
    spot("hpos_after_line", a_hpos, 0);
    spot("vpos_after_line", a_vpos, 1);
    spot("pol_hsync_high_cycles", phs_cnt, 96);
    spot("pol_hsync_first_hpos", phs_first, 656);

    // Stall-interleaved line wrap
    for (int i = 0; i < 790; i++) step(1'b1);
    ls_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(i % 2 == 0);
      if (a_ls) ls_cnt++;
      if (a_de && de_rise < 0) de_rise = i;
      if (a_ded && ded_rise < 0) ded_rise = i;
    end
    spot("stall_line_start_clocks", ls_cnt, 1);
    spot("stall_delay_lag_clocks", ded_rise - de_rise, 4);
    spot("stall_hpos", a_hpos, 10);
    spot("stall_vpos", a_vpos, 2);

    // Mid-line reset while hsync is active
    for (int i = 0; i < 690; i++) step(1'b1);
    spot("pre_rst_a_hpos", a_hpos, 700);
    spot("pre_rst_a_hsync", a_hs, 0);
    do_reset();

    // 256 small frames: frame_count wraps 255 -> 0 with frame_start
    for (int i = 0; i < 32768; i++) begin
      step(1'b1);
      if (s_fs) fs_cnt++;
      if (i < 128 && !s_vs) begin
        vs_low++;
        if (s_vpos != 10'd5 && s_vpos != 10'd6) vs_bad++;
      end
      if (i == 127) begin
        spot("small_fc_first_frame", s_fc, 1);
        spot("small_fs_first_frame", s_fs, 1);
      end
    end
    spot("small_vsync_low_cycles", vs_low, 32);
    spot("small_vsync_outside_lines", vs_bad, 0);
    spot("small_frame_starts", fs_cnt, 256);
    spot("small_fc_wrap", s_fc, 0);
    spot("small_fs_at_wrap", s_fs, 1);

    // Reset with both syncs (and their delayed copies) active
    for (int i = 0; i < 92; i++) step(1'b1);
    spot("pre_rst_s_hsync", s_hs, 0);
    spot("pre_rst_s_vsync", s_vs, 0);
    spot("pre_rst_s_hsync_d", s_hsd, 0);
    spot("pre_rst_s_vsync_d", s_vsd, 0);
    do_reset();

    for (int i = 0; i < 4; i++) step(1'b1);
    spot("queue_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
